mitch_dot_accum: RTL and testbench



---
 rtl/mitch_dot_accum_pkg.sv | 29 ++
 rtl/mitch_sat_add.sv | 48 ++++
 rtl/mitch_dot_accum.sv | 115 +++++++++++
 tb/tb_mitch_dot_accum.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mitch_dot_accum_pkg.sv
// Shared definitions for the Mitchell dot-product accumulator.
//   state_t        : accumulator FSM states
//   PROD_W         : width of the incoming multiplier product
//   ACC_W_DEF /
//   CNT_W_DEF      : default accumulator and term-counter widths
//   max_s / min_s  : signed limits of a given width, returned in 64 bits
//                    (callers keep the low 'width' bits)
package mitch_dot_accum_pkg;

    localparam int PROD_W    = 32;
    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    function automatic logic [63:0] max_s(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Bit pattern 1000...0 in the low 'width' bits.
    function automatic logic [63:0] min_s(input int width);
        return ~max_s(width);
    endfunction

endpackage

// File: rtl/mitch_sat_add.sv
// Combinational accumulate step: acc + sign-extended product + carry-in,
// evaluated in ACC_W+1 bits so that signed overflow is visible, then
// optionally clamped to the signed ACC_W range.
//   acc  : current accumulator value (signed, ACC_W)
//   prod : signed product (PROD_W)
//   cin  : carry-in (one's-complement fix-up bit)
//   sum  : next accumulator value (clamped or wrapped)
//   ovf  : clamping happened this step (always 0 when SATURATE = 0)
module mitch_sat_add
    import mitch_dot_accum_pkg::*;
#(
    parameter int ACC_W    = ACC_W_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    input  logic              cin,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    localparam int               EXT_W   = ACC_W + 1 - PROD_W;
    localparam logic [ACC_W-1:0] SUM_MAX = ACC_W'(max_s(ACC_W));
    localparam logic [ACC_W-1:0] SUM_MIN = ACC_W'(min_s(ACC_W));

    logic [ACC_W:0] sum_raw;
    logic           raw_ovf;

    assign sum_raw = {acc[ACC_W-1], acc}
                   + {{EXT_W{prod[PROD_W-1]}}, prod}
                   + {{ACC_W{1'b0}}, cin};

    // The top two bits disagree exactly when the true result left the
    // signed ACC_W range; the top bit then carries the true sign.
    assign raw_ovf = sum_raw[ACC_W] ^ sum_raw[ACC_W-1];

    // NOTE: every output gets a default before the conditional override so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        sum = sum_raw[ACC_W-1:0];
        ovf = 1'b0;
        if (SATURATE && raw_ovf) begin
            ovf = 1'b1;
            sum = sum_raw[ACC_W] ? SUM_MIN : SUM_MAX;
        end
    end

endmodule

// File: rtl/mitch_dot_accum.sv
// Dot-product accumulator behind the truncated Mitchell log multiplier.
// Sums a packet of signed 32-bit products (terminated by in_last) into a
// wide signed result, with valid/ready on both sides.
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : product beat valid
//   in_ready     : beat can be accepted (low while a result is held)
//   in_prod      : signed product; negatives may be one's complement
//   in_last      : final term of the packet, qualified by in_valid
//   out_valid    : result valid, held until out_ready
//   out_ready    : consumer takes the result
//   out_sum      : accumulated signed sum
//   out_count    : accepted terms in the packet, saturating
//   out_sat      : sum was clamped at least once in the packet
module mitch_dot_accum
    import mitch_dot_accum_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter bit ONES_COMP = 1'b1,
    parameter bit SATURATE  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sat;
    logic             sat_next;
    logic             step_ovf;
    logic             carry_in;
    logic             accept;

    // Combinational from state so the input side reopens the same cycle
    // the FSM leaves DONE.
    assign in_ready = (state != DONE);
    assign accept   = in_valid & in_ready;

    // One's-complement negatives are one below the true value; adding the
    // sign bit as carry-in restores it. Zero has sign 0, so it adds nothing.
    assign carry_in = ONES_COMP & in_prod[PROD_W-1];

    mitch_sat_add #(
        .ACC_W   (ACC_W),
        .SATURATE(SATURATE)
    ) u_sat_add (
        .acc (acc),
        .prod(in_prod),
        .cin (carry_in),
        .sum (acc_next),
        .ovf (step_ovf)
    );

    assign cnt_next = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign sat_next = sat | step_ovf;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        sat <= sat_next;
                        if (in_last) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_sum   <= acc_next;
                            out_count <= cnt_next;
                            out_sat   <= sat_next;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    // Result registers keep their value after the handshake;
                    // only the packet state is cleared.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        sat       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mitch_dot_accum.sv
// Scoreboard bench for mitch_dot_accum. Four instances with different
// width / sign-encoding / saturation settings share one input stream; a
// packet-level arithmetic model predicts every result, and a monitor
// compares whenever a result is handed over.
module tb_mitch_dot_accum;
    import mitch_dot_accum_pkg::*;

    localparam int N = 4;

    // Instance settings: 0: 40/16 oc sat, 1: 40/16 tc sat,
    //                    2: 32/4  oc sat, 3: 32/4  tc wrap
    function automatic int acc_w_of(input int i);
        return (i < 2) ? 40 : 32;
    endfunction
    function automatic int cnt_w_of(input int i);
        return (i < 2) ? 16 : 4;
    endfunction
    function automatic bit oc_of(input int i);
        return (i == 0 || i == 2);
    endfunction
    function automatic bit sat_of(input int i);
        return (i != 3);
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_prod = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic [N-1:0] rdy;
    logic [N-1:0] vld;
    logic [N-1:0] satf;
    logic [39:0]  sum0, sum1;
    logic [31:0]  sum2, sum3;
    logic [15:0]  cnt0, cnt1;
    logic [3:0]   cnt2, cnt3;

    longint o_sum [N];
    longint o_cnt [N];

    always #5 clk = ~clk;

    mitch_dot_accum #(.ACC_W(40), .CNT_W(16), .ONES_COMP(1'b1), .SATURATE(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_prod(in_prod),
        .in_last(in_last), .out_valid(vld[0]), .out_ready(out_ready), .out_sum(sum0),
        .out_count(cnt0), .out_sat(satf[0]));
    mitch_dot_accum #(.ACC_W(40), .CNT_W(16), .ONES_COMP(1'b0), .SATURATE(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_prod(in_prod),
        .in_last(in_last), .out_valid(vld[1]), .out_ready(out_ready), .out_sum(sum1),
        .out_count(cnt1), .out_sat(satf[1]));
    mitch_dot_accum #(.ACC_W(32), .CNT_W(4), .ONES_COMP(1'b1), .SATURATE(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_prod(in_prod),
        .in_last(in_last), .out_valid(vld[2]), .out_ready(out_ready), .out_sum(sum2),
        .out_count(cnt2), .out_sat(satf[2]));
    mitch_dot_accum #(.ACC_W(32), .CNT_W(4), .ONES_COMP(1'b0), .SATURATE(1'b0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]), .in_prod(in_prod),
        .in_last(in_last), .out_valid(vld[3]), .out_ready(out_ready), .out_sum(sum3),
        .out_count(cnt3), .out_sat(satf[3]));

    always_comb begin
        o_sum[0] = longint'(signed'(sum0));
        o_sum[1] = longint'(signed'(sum1));
        o_sum[2] = longint'(signed'(sum2));
        o_sum[3] = longint'(signed'(sum3));
        o_cnt[0] = longint'(cnt0);
        o_cnt[1] = longint'(cnt1);
        o_cnt[2] = longint'(cnt2);
        o_cnt[3] = longint'(cnt3);
    end

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct packed {
        logic [N-1:0][63:0] sum;
        logic [N-1:0][63:0] cnt;
        logic [N-1:0]       sat;
    } exp_t;

    exp_t exp_q [$];

    // ---------------- reference model (packet arithmetic) ----------------
    longint m_acc [N];
    longint m_cnt [N];
    bit     m_sat [N];

    function automatic longint wrap_to(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
            m_sat[i] = 1'b0;
        end
    endtask

    task automatic model_beat(input logic [31:0] p, input logic last);
        longint v, s, maxv, minv;
        exp_t   e;
        for (int i = 0; i < N; i++) begin
            v = longint'(signed'(p));
            if (oc_of(i) && p[31]) v = v + 1;
            s    = m_acc[i] + v;
            maxv = (longint'(1) <<< (acc_w_of(i) - 1)) - 1;
            minv = -maxv - 1;
            if (sat_of(i)) begin
                if (s > maxv) begin
                    s = maxv;
                    m_sat[i] = 1'b1;
                end else if (s < minv) begin
                    s = minv;
                    m_sat[i] = 1'b1;
                end
            end else begin
                s = wrap_to(s, acc_w_of(i));
            end
            m_acc[i] = s;
            if (m_cnt[i] < (longint'(1) <<< cnt_w_of(i)) - 1) m_cnt[i] = m_cnt[i] + 1;
        end
        if (last) begin
            for (int i = 0; i < N; i++) begin
                e.sum[i] = m_acc[i];
                e.cnt[i] = m_cnt[i];
                e.sat[i] = m_sat[i];
            end
            exp_q.push_back(e);
            model_clear();
        end
    endtask

    // ---------------- monitor ----------------
    bit     hold_pending = 1'b0;
    longint prev_sum [N];
    longint prev_cnt [N];
    logic   prev_sat [N];

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                for (int i = 0; i < N; i++) begin
                    check($sformatf("hold_valid[%0d]", i), vld[i], 1);
                    check($sformatf("hold_sum[%0d]", i), o_sum[i], prev_sum[i]);
                    check($sformatf("hold_count[%0d]", i), o_cnt[i], prev_cnt[i]);
                    check($sformatf("hold_sat[%0d]", i), satf[i], prev_sat[i]);
                end
            end
            if (vld[0]) begin
                for (int i = 0; i < N; i++)
                    check($sformatf("in_ready_busy[%0d]", i), rdy[i], 0);
                if (out_ready) begin
                    hold_pending = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("pending_results", longint'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        for (int i = 0; i < N; i++) begin
                            check($sformatf("valid[%0d]", i), vld[i], 1);
                            check($sformatf("sum[%0d]", i), o_sum[i], longint'(e.sum[i]));
                            check($sformatf("count[%0d]", i), o_cnt[i], longint'(e.cnt[i]));
                            check($sformatf("sat[%0d]", i), satf[i], e.sat[i]);
                        end
                    end
                end else begin
                    hold_pending = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        prev_sum[i] = o_sum[i];
                        prev_cnt[i] = o_cnt[i];
                        prev_sat[i] = satf[i];
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    bit rand_ready = 1'b0;

    // Called between edges; returns 1 time unit after the accepting edge.
    // in_valid is left high so the caller decides whether to idle.
    task automatic send_beat(input logic [31:0] p, input logic last, output int stalls);
        bit done;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        stalls   = 0;
        done     = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (rdy[0]) begin
                @(posedge clk);
                model_beat(p, last);
                #1;
                done = 1'b1;
            end else begin
                stalls++;
                @(posedge clk);
                #1;
                if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            in_last = 1'($urandom);
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int len;
        logic [31:0] p;

        model_clear();

        // Reset state
        #3;
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_valid[%0d]", i), vld[i], 0);
            check($sformatf("rst_sum[%0d]", i), o_sum[i], 0);
            check($sformatf("rst_count[%0d]", i), o_cnt[i], 0);
            check($sformatf("rst_sat[%0d]", i), satf[i], 0);
            check($sformatf("rst_in_ready[%0d]", i), rdy[i], 1);
        end
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: three beats of 100, out_valid exactly one cycle after beat 3
        send_beat(32'd100, 1'b0, st);
        send_beat(32'd100, 1'b0, st);
        send_beat(32'd100, 1'b1, st);
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_valid_rise", vld[0], 1);
        @(negedge clk);
        check("t1_valid_fall", vld[0], 0);
        @(posedge clk);
        #1;

        // 2: one's-complement -100 then 200
        send_beat(32'hFFFF_FF9B, 1'b0, st);
        send_beat(32'h0000_00C8, 1'b1, st);
        idle_cycles(2);

        // 3: positive overflow, clamp vs wrap in the 32-bit instances
        send_beat(32'h7FFF_FFFF, 1'b0, st);
        send_beat(32'h7FFF_FFFF, 1'b1, st);
        idle_cycles(2);

        // Negative overflow, zero products and counter saturation
        send_beat(32'h8000_0000, 1'b0, st);
        send_beat(32'h8000_0000, 1'b1, st);
        for (int k = 0; k < 4; k++) send_beat(32'h0, k == 3, st);
        for (int k = 0; k < 20; k++) send_beat(32'd1, k == 19, st);
        idle_cycles(2);

        // 4: backpressure while a rejected beat waits
        out_ready = 1'b0;
        send_beat(32'd5, 1'b1, st);
        in_valid = 1'b1;
        in_prod  = 32'd9;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", rdy[0], 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_beat(32'd9, 1'b1, st);
        idle_cycles(3);

        // 5: asynchronous reset mid-packet
        send_beat(32'd10, 1'b0, st);
        send_beat(32'd20, 1'b0, st);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("async_valid[%0d]", i), vld[i], 0);
            check($sformatf("async_sum[%0d]", i), o_sum[i], 0);
            check($sformatf("async_in_ready[%0d]", i), rdy[i], 1);
        end
        model_clear();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(32'd7, 1'b1, st);
        idle_cycles(3);

        // 6: back-to-back two-beat packets, one stall per DONE cycle
        for (int pk = 0; pk < 6; pk++) begin
            for (int b = 0; b < 2; b++) begin
                send_beat($urandom, b == 1, st);
                check("b2b_stalls", st, (pk > 0 && b == 0) ? 1 : 0);
            end
        end
        idle_cycles(3);

        // Randomized packets with gaps and random out_ready
        rand_ready = 1'b1;
        for (int pk = 0; pk < 40; pk++) begin
            len = $urandom_range(1, 20);
            for (int b = 0; b < len; b++) begin
                case ($urandom_range(0, 3))
                    0:       p = $urandom;
                    1:       p = 32'($urandom_range(0, 4000)) - 32'd2000;
                    2:       p = {1'b0, 31'($urandom)} | 32'h7000_0000;
                    default: p = {1'b1, 31'($urandom)} & 32'h8FFF_FFFF;
                endcase
                send_beat(p, b == len - 1, st);
                if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            end
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        idle_cycles(10);
        check("queue_drained", longint'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
